// File: rtl/cam_pkg.sv
// Shared camera-pipeline constants: frame geometry defaults,
// RGB565 field positions, direction codes and tracker states.
package cam_pkg;

   localparam int H_RES_DEF = 320;
   localparam int V_RES_DEF = 240;

   localparam int R_HI = 15;
   localparam int R_LO = 11;
   localparam int G_HI = 10;
   localparam int G_LO = 5;
   localparam int B_HI = 4;
   localparam int B_LO = 0;

   typedef enum logic [1:0] {
      DIR_NONE   = 2'b00,
      DIR_LEFT   = 2'b01,
      DIR_CENTER = 2'b10,
      DIR_RIGHT  = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_LATCH = 2'd2
   } trk_state_e;

endpackage

// File: rtl/color_sector_tracker_match.sv
// rgb565_color_match: combinational target-colour threshold test
// on one RGB565 pixel.
module rgb565_color_match
   import cam_pkg::*;
#(
   parameter logic [4:0] R_MIN = 5'd20,
   parameter logic [5:0] G_MAX = 6'd24,
   parameter logic [4:0] B_MAX = 5'd12
) (
   input  logic [15:0] pixel,
   output logic        match
);

   always_comb begin
      match = (pixel[R_HI:R_LO] >= R_MIN)
           && (pixel[G_HI:G_LO] <= G_MAX)
           && (pixel[B_HI:B_LO] <= B_MAX);
   end

endmodule

// File: rtl/color_sector_tracker.sv
// color_sector_tracker: counts target-colour pixels in three vertical
// sectors per frame and publishes counts plus a steering direction.
module color_sector_tracker
   import cam_pkg::*;
#(
   parameter int         H_RES     = H_RES_DEF,
   parameter int         V_RES     = V_RES_DEF,
   parameter int         CNT_W     = 17,
   parameter logic [4:0] R_MIN     = 5'd20,
   parameter logic [5:0] G_MAX     = 6'd24,
   parameter logic [4:0] B_MAX     = 5'd12,
   parameter int         MIN_COUNT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_pixel,
   input  logic [15:0]      pixel,
   input  logic             end_line,
   input  logic             end_frame,
   input  logic             track_en,
   output logic [CNT_W-1:0] cnt_left,
   output logic [CNT_W-1:0] cnt_center,
   output logic [CNT_W-1:0] cnt_right,
   output logic [1:0]       direction,
   output logic             result_valid,
   output logic             frame_ok
);

   localparam int XW = $clog2(H_RES + 1);
   localparam int YW = $clog2(V_RES + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_COUNT);
   localparam logic [XW-1:0] X_END = XW'(H_RES);
   localparam logic [XW-1:0] X_S1  = XW'(H_RES / 3);
   localparam logic [XW-1:0] X_S2  = XW'((2 * H_RES) / 3);
   localparam logic [YW-1:0] Y_OK  = YW'(V_RES);

   logic pix_match;
   logic d_new, d_el, d_ef, d_match;

   rgb565_color_match #(
      .R_MIN (R_MIN),
      .G_MAX (G_MAX),
      .B_MAX (B_MAX)
   ) u_match (
      .pixel (pixel),
      .match (pix_match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         d_new   <= 1'b0;
         d_el    <= 1'b0;
         d_ef    <= 1'b0;
         d_match <= 1'b0;
      end else begin
         d_new   <= new_pixel;
         d_el    <= end_line;
         d_ef    <= end_frame;
         d_match <= pix_match;
      end
   end

   trk_state_e state, state_n;
   logic load, clr;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_SYNC;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      clr     = 1'b0;
      unique case (state)
         ST_SYNC: begin
            if (d_ef) state_n = ST_ACCUM;
         end
         ST_ACCUM, ST_LATCH: begin
            state_n = ST_ACCUM;
            if (d_ef) begin
               clr = 1'b1;
               if (track_en) begin
                  load    = 1'b1;
                  state_n = ST_LATCH;
               end
            end
         end
         default: state_n = ST_SYNC;
      endcase
   end

   logic [XW-1:0]    x;
   logic [YW-1:0]    y, y_nx;
   logic [CNT_W-1:0] acc_l, acc_c, acc_r;
   logic [CNT_W-1:0] nl, nc, nr, mx;
   logic             hit, hit_l, hit_c, hit_r;
   dir_e             dsel, dir_n;

   function automatic logic [CNT_W-1:0] bump(
      input logic [CNT_W-1:0] v,
      input logic             en
   );
      return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
   endfunction

   // The closing frame's counts include a pixel arriving with end_frame.
   always_comb begin
      hit   = d_new && d_match && (state != ST_SYNC);
      hit_l = hit && (x < X_S1);
      hit_c = hit && (x >= X_S1) && (x < X_S2);
      hit_r = hit && (x >= X_S2) && (x < X_END);
      nl    = bump(acc_l, hit_l);
      nc    = bump(acc_c, hit_c);
      nr    = bump(acc_r, hit_r);
      y_nx  = (d_el && y != '1) ? y + YW'(1) : y;
   end

   always_comb begin
      mx   = nr;
      dsel = DIR_RIGHT;
      if (nc >= nl && nc >= nr) begin
         mx   = nc;
         dsel = DIR_CENTER;
      end else if (nl >= nr) begin
         mx   = nl;
         dsel = DIR_LEFT;
      end
      dir_n = (mx < CNT_MIN) ? DIR_NONE : dsel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x            <= '0;
         y            <= '0;
         acc_l        <= '0;
         acc_c        <= '0;
         acc_r        <= '0;
         cnt_left     <= '0;
         cnt_center   <= '0;
         cnt_right    <= '0;
         direction    <= DIR_NONE;
         frame_ok     <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         if (d_el || d_ef)               x <= '0;
         else if (d_new && x != X_END) x <= x + XW'(1);
         y <= d_ef ? '0 : y_nx;
         if (clr) begin
            acc_l <= '0;
            acc_c <= '0;
            acc_r <= '0;
         end else begin
            acc_l <= nl;
            acc_c <= nc;
            acc_r <= nr;
         end
         result_valid <= load;
         if (load) begin
            cnt_left   <= nl;
            cnt_center <= nc;
            cnt_right  <= nr;
            direction  <= dir_n;
            frame_ok   <= (y_nx == Y_OK);
         end
      end
   end

endmodule

// File: tb/tb_color_sector_tracker.sv
// Bench for color_sector_tracker: table vectors, corner sequences
// and randomized frames against a sector-count reference model.
module tb_color_sector_tracker;

   localparam int H    = 12;
   localparam int V    = 4;
   localparam int MINC = 2;
   localparam int CW   = 17;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          new_pixel = 1'b0;
   logic [15:0]   pixel = '0;
   logic          end_line = 1'b0;
   logic          end_frame = 1'b0;
   logic          track_en = 1'b1;
   logic [CW-1:0] cnt_left, cnt_center, cnt_right;
   logic [1:0]    direction;
   logic          result_valid, frame_ok;

   int nvec = 0;
   int nmiss = 0;
   int rv_count = 0;
   int cap_l[$];
   int mdl_l, mdl_c, mdl_r;

   typedef struct {
      int          lines;
      int          ppl;
      logic [15:0] mask;
      int          mlines;
      bit          merge;
      int          l, c, r, dir;
      bit          ok;
   } vec_t;

   vec_t tbl[10];

   always #5 clk = ~clk;

   color_sector_tracker #(
      .H_RES     (H),
      .V_RES     (V),
      .CNT_W     (CW),
      .MIN_COUNT (MINC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .new_pixel    (new_pixel),
      .pixel        (pixel),
      .end_line     (end_line),
      .end_frame    (end_frame),
      .track_en     (track_en),
      .cnt_left     (cnt_left),
      .cnt_center   (cnt_center),
      .cnt_right    (cnt_right),
      .direction    (direction),
      .result_valid (result_valid),
      .frame_ok     (frame_ok)
   );

   always @(negedge clk) begin
      if (result_valid) begin
         rv_count++;
         cap_l.push_back(int'(cnt_left));
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmiss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic np, input logic [15:0] px,
                      input logic el, input logic ef);
      @(negedge clk);
      new_pixel = np;
      pixel     = px;
      end_line  = el;
      end_frame = ef;
   endtask

   function automatic bit ref_match(input logic [15:0] p);
      return (p[15:11] >= 5'd20) && (p[10:5] <= 6'd24) && (p[4:0] <= 5'd12);
   endfunction

   function automatic logic [15:0] mk_match();
      logic [4:0] r = 5'($urandom_range(31, 20));
      logic [5:0] g = 6'($urandom_range(24, 0));
      logic [4:0] b = 5'($urandom_range(12, 0));
      return {r, g, b};
   endfunction

   function automatic logic [15:0] mk_miss();
      logic [15:0] p = mk_match();
      case ($urandom_range(2, 0))
         0:       p[15:11] = 5'($urandom_range(19, 0));
         1:       p[10:5]  = 6'($urandom_range(63, 25));
         default: p[4:0]   = 5'($urandom_range(31, 13));
      endcase
      return p;
   endfunction

   function automatic int ref_dir(input int l, input int c, input int r);
      int mx = l;
      if (c > mx) mx = c;
      if (r > mx) mx = r;
      if (mx < MINC) return 0;
      if (c == mx)   return 2;
      if (l == mx)   return 1;
      return 3;
   endfunction

   task automatic send_frame(input int lines, input int ppl,
                             input logic [15:0] mask, input int mlines,
                             input bit merge, input bit rnd,
                             input bit gap, input bit do_ef);
      mdl_l = 0;
      mdl_c = 0;
      mdl_r = 0;
      for (int ln = 0; ln < lines; ln++) begin
         for (int i = 0; i < ppl; i++) begin
            logic [15:0] px;
            bit want, last, fin;
            if (rnd) want = bit'($urandom_range(1, 0));
            else     want = (ln < mlines) && (i < 16) && mask[i[3:0]];
            px = want ? mk_match() : mk_miss();
            if (rnd && $urandom_range(3, 0) == 0) px = 16'($urandom);
            if (ref_match(px) && i < H) begin
               if (i < H / 3)          mdl_l++;
               else if (i < 2 * H / 3) mdl_c++;
               else                    mdl_r++;
            end
            last = (i == ppl - 1);
            fin  = merge && last && do_ef && (ln == lines - 1);
            cyc(1'b1, px, merge && last, fin);
            if (gap && !fin)
               repeat ($urandom_range(2, 0)) cyc(1'b0, '0, 1'b0, 1'b0);
         end
         if (!merge) cyc(1'b0, '0, 1'b1, 1'b0);
      end
      if (!merge && do_ef) cyc(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic expect_result(input string nm, input bit v,
                                input int l, input int c, input int r,
                                input int d, input bit ok);
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk({nm, "_early"}, int'(result_valid), 0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk({nm, "_valid"}, int'(result_valid), int'(v));
      if (v) begin
         chk({nm, "_left"},   int'(cnt_left),   l);
         chk({nm, "_center"}, int'(cnt_center), c);
         chk({nm, "_right"},  int'(cnt_right),  r);
         chk({nm, "_dir"},    int'(direction),  d);
         chk({nm, "_ok"},     int'(frame_ok),   int'(ok));
      end
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk({nm, "_pulse"}, int'(result_valid), 0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_left"},   int'(cnt_left),     0);
      chk({nm, "_center"}, int'(cnt_center),   0);
      chk({nm, "_right"},  int'(cnt_right),    0);
      chk({nm, "_dir"},    int'(direction),    0);
      chk({nm, "_ok"},     int'(frame_ok),     0);
      chk({nm, "_rv"},     int'(result_valid), 0);
   endtask

   initial begin
      int n0;
      tbl[0] = '{4, 12, 16'h0000, 4, 1'b0,  0,  0,  0, 0, 1'b1};
      tbl[1] = '{4, 12, 16'h000F, 4, 1'b0, 16,  0,  0, 1, 1'b1};
      tbl[2] = '{4, 12, 16'h0110, 4, 1'b0,  0,  4,  4, 2, 1'b1};
      tbl[3] = '{4, 12, 16'h0800, 1, 1'b0,  0,  0,  1, 0, 1'b1};
      tbl[4] = '{3, 14, 16'h3000, 3, 1'b0,  0,  0,  0, 0, 1'b0};
      tbl[5] = '{4, 12, 16'h00F0, 4, 1'b1,  0, 16,  0, 2, 1'b1};
      tbl[6] = '{4, 12, 16'h0F00, 4, 1'b0,  0,  0, 16, 3, 1'b1};
      tbl[7] = '{4, 12, 16'h0101, 4, 1'b0,  4,  0,  4, 1, 1'b1};
      tbl[8] = '{5, 12, 16'h0F00, 2, 1'b1,  0,  0,  8, 3, 1'b0};
      tbl[9] = '{4, 12, 16'h0801, 4, 1'b1,  4,  0,  4, 1, 1'b1};

      repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
      chk_zero("reset");
      rst = 1'b0;

      send_frame(2, 12, 16'h000F, 2, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_result("partial", 1'b0, 0, 0, 0, 0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         send_frame(tbl[i].lines, tbl[i].ppl, tbl[i].mask, tbl[i].mlines,
                    tbl[i].merge, 1'b0, 1'b0, 1'b1);
         expect_result($sformatf("tbl%0d", i), 1'b1, tbl[i].l, tbl[i].c,
                       tbl[i].r, tbl[i].dir, tbl[i].ok);
      end

      n0 = rv_count;
      send_frame(4, 12, 16'h000F, 4, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(4, 12, 16'h0003, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_result("b2b", 1'b1, 2, 0, 0, 1, 1'b1);
      chk("b2b_count", rv_count - n0, 2);
      chk("b2b_first", cap_l[cap_l.size() - 2], 16);

      track_en = 1'b0;
      n0 = rv_count;
      send_frame(4, 12, 16'h00F0, 4, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_result("disabled", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("dis_hold_left", int'(cnt_left), 2);
      chk("dis_hold_dir", int'(direction), 1);
      track_en = 1'b1;
      send_frame(4, 12, 16'h0F00, 4, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_result("reenabled", 1'b1, 0, 0, 16, 3, 1'b1);
      chk("dis_count", rv_count - n0, 1);

      send_frame(2, 12, 16'h000F, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'hF800, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk_zero("midrst");
      rst = 1'b0;
      send_frame(2, 12, 16'h000F, 2, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_result("resync", 1'b0, 0, 0, 0, 0, 1'b0);
      send_frame(4, 12, 16'h0110, 4, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_result("after_rst", 1'b1, 0, 4, 4, 2, 1'b1);

      for (int k = 0; k < 25; k++) begin
         int ln = $urandom_range(5, 3);
         int pp = $urandom_range(14, 10);
         bit mg = bit'($urandom_range(1, 0));
         track_en = ($urandom_range(4, 0) != 0);
         send_frame(ln, pp, '0, 0, mg, 1'b1, 1'b1, 1'b1);
         expect_result($sformatf("rnd%0d", k), track_en, mdl_l, mdl_c,
                       mdl_r, ref_dir(mdl_l, mdl_c, mdl_r), ln == V);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end

endmodule
